// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared arithmetic constants, FSM encodings and helpers
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: one-bit combinational full adder
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder with valid/ready handshake on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic [N-1:0] i_augend,
    input  logic [N-1:0] i_addend,
    input  logic         i_carry_in,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [N-1:0] o_sum,
    output logic         o_carry,
    output logic         o_overflow,
    output logic         o_valid,
    input  logic         i_ready
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;
    logic          fa_s, fa_c;

    full_adder u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .sum (fa_s),
        .cout(fa_c)
    );

    // next state and datapath: load on accept, one bit per RUN cycle, publish result on the last bit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_augend;
                    b_d     = i_addend;
                    carry_d = i_carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {fa_s, acc_q[N-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, acc_q[N-1:1]};
                    co_d    = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register; reset drops any in-flight operation and clears the published result
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_sum      = sum_q;
    assign o_carry    = co_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the serial adder with hand-computed results
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [7:0] i_augend = '0;
    logic [7:0] i_addend = '0;
    logic       i_carry_in = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic       o_ready;
    logic [7:0] o_sum;
    logic       o_carry;
    logic       o_overflow;
    logic       o_valid;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) dut (
        .i_clock   (clk),
        .i_reset_n (i_reset_n),
        .i_augend  (i_augend),
        .i_addend  (i_addend),
        .i_carry_in(i_carry_in),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_sum     (o_sum),
        .o_carry   (o_carry),
        .o_overflow(o_overflow),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // accept an operation, scramble inputs during RUN, wait for DONE and check the result
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [7:0] es, input logic ec, input logic eo);
        int edges;
        @(negedge clk);
        i_augend   = a;
        i_addend   = b;
        i_carry_in = cin;
        i_valid    = 1'b1;
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        i_augend   = ~a;
        i_addend   = a ^ 8'h5a;
        i_carry_in = ~cin;
        while (!o_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        check("latency_edges_incl_accept", 32'(edges), 32'd9);
        check("sum", 32'(o_sum), 32'(es));
        check("carry", 32'(o_carry), 32'(ec));
        check("overflow", 32'(o_overflow), 32'(eo));
    endtask

    // hand off the result while offering a new operation; it must not be taken on the same edge
    task automatic finish_op(input logic [7:0] es);
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_augend = 8'hff;
        i_addend = 8'hff;
        @(posedge clk);
        @(negedge clk);
        check("valid_after_handoff", 32'(o_valid), 32'd0);
        check("ready_after_handoff", 32'(o_ready), 32'd1);
        check("sum_held_in_idle", 32'(o_sum), 32'(es));
        i_ready = 1'b0;
        i_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sum", 32'(o_sum), 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_release", 32'(o_ready), 32'd1);

        start_op(8'd3, 8'd5, 1'b0, 8'd8, 1'b0, 1'b0);
        finish_op(8'd8);
        start_op(8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
        finish_op(8'd0);
        start_op(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
        finish_op(8'd128);

        start_op(8'd200, 8'd100, 1'b1, 8'd45, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            i_valid  = i[0];
            i_augend = 8'($urandom);
            i_addend = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 32'(o_valid), 32'd1);
            check("bp_ready", 32'(o_ready), 32'd0);
            check("bp_sum", 32'(o_sum), 32'd45);
            check("bp_carry", 32'(o_carry), 32'd1);
            check("bp_overflow", 32'(o_overflow), 32'd0);
        end
        i_valid = 1'b0;
        finish_op(8'd45);

        @(negedge clk);
        i_augend = 8'h55;
        i_addend = 8'h0f;
        i_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_valid", 32'(o_valid), 32'd0);
        check("midrun_rst_sum", 32'(o_sum), 32'd0);
        check("midrun_rst_carry", 32'(o_carry), 32'd0);
        check("midrun_rst_overflow", 32'(o_overflow), 32'd0);
        i_reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_ready", 32'(o_ready), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("no_partial_valid", 32'(o_valid), 32'd0);

        start_op(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);
        finish_op(8'd30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
